// File: rtl/dpsk_loop_filter.sv
// Carrier-tracking loop filter for the DPSK receiver: mixes each received sample with one VCO
// sample, integrates-and-dumps over N_INT products and drives the VCO step through a PI filter.
module dpsk_loop_filter #(
    parameter int unsigned N_INT = 16,
    parameter int unsigned KP_SH = 6,
    parameter int unsigned KI_SH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [7:0]  rx_in,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        rd_en,
    input  logic [7:0]  vco_out,
    output logic [10:0] dlt_step,
    output logic        step_valid
);

    typedef enum logic [1:0] {StIdle, StReq, StCap, StFilt} state_e;

    localparam logic [8:0]         NIntCnt  = 9'(N_INT);
    localparam logic signed [33:0] IntegMax = 34'sd2147483647;
    localparam logic signed [33:0] IntegMin = -34'sd2147483648;
    localparam logic signed [32:0] StepMax  = 33'sd1023;
    localparam logic signed [32:0] StepMin  = -33'sd1024;

    state_e             state_q, state_d;
    logic [7:0]         rx_q, rx_d;
    logic signed [23:0] acc_q, acc_d;
    logic [8:0]         cnt_q, cnt_d;
    logic signed [31:0] integ_q, integ_d;
    logic [10:0]        step_q, step_d;
    logic               step_valid_q, step_valid_d;

    logic signed [15:0] prod;
    logic signed [33:0] integ_sum;
    logic signed [31:0] integ_n;
    logic signed [32:0] acc_ext, integ_ext;
    logic signed [32:0] p_term, i_term, pi_sum;
    logic [10:0]        step_sat;

    assign prod = $signed(rx_q) * $signed(vco_out);

    // Integrator update and PI sum; only consumed in StFilt.
    always_comb begin
        integ_sum = $signed({{2{integ_q[31]}}, integ_q}) + $signed({{10{acc_q[23]}}, acc_q});
        if (integ_sum > IntegMax) begin
            integ_n = 32'sh7fff_ffff;
        end else if (integ_sum < IntegMin) begin
            integ_n = 32'sh8000_0000;
        end else begin
            integ_n = integ_sum[31:0];
        end
        acc_ext   = $signed({{9{acc_q[23]}}, acc_q});
        integ_ext = $signed({integ_n[31], integ_n});
        p_term    = acc_ext >>> KP_SH;
        i_term    = integ_ext >>> KI_SH;
        pi_sum    = p_term + i_term;
        if (pi_sum > StepMax) begin
            step_sat = 11'h3ff;
        end else if (pi_sum < StepMin) begin
            step_sat = 11'h400;
        end else begin
            step_sat = pi_sum[10:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        rx_d         = rx_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        integ_d      = integ_q;
        step_d       = step_q;
        step_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    rx_d    = rx_in;
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StCap;
            end
            StCap: begin
                acc_d   = acc_q + $signed({{8{prod[15]}}, prod});
                cnt_d   = cnt_q + 9'd1;
                state_d = (cnt_d == NIntCnt) ? StFilt : StIdle;
            end
            StFilt: begin
                integ_d      = integ_n;
                step_d       = step_sat;
                step_valid_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Loop clear wins over everything, dropping any sample in flight.
        if (clr) begin
            state_d      = StIdle;
            rx_d         = '0;
            acc_d        = '0;
            cnt_d        = '0;
            integ_d      = '0;
            step_d       = '0;
            step_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rx_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            integ_q      <= '0;
            step_q       <= '0;
            step_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_q         <= rx_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            integ_q      <= integ_d;
            step_q       <= step_d;
            step_valid_q <= step_valid_d;
        end
    end

    assign rx_ready   = (state_q == StIdle);
    assign rd_en      = (state_q == StReq);
    assign dlt_step   = step_q;
    assign step_valid = step_valid_q;

endmodule

// File: tb/tb_dpsk_loop_filter.sv
// Scoreboarded bench for dpsk_loop_filter: an arithmetic window/PI model predicts each step update,
// a monitor checks every step_valid pulse, its timing and the held value in between.
module tb_dpsk_loop_filter;

    localparam int N_INT = 16;
    localparam int KP_SH = 6;
    localparam int KI_SH = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  rx_in = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        rd_en;
    logic [7:0]  vco_out = '0;
    logic [10:0] dlt_step;
    logic        step_valid;

    dpsk_loop_filter #(
        .N_INT(N_INT),
        .KP_SH(KP_SH),
        .KI_SH(KI_SH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .rx_in     (rx_in),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rd_en     (rd_en),
        .vco_out   (vco_out),
        .dlt_step  (dlt_step),
        .step_valid(step_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint at;
        longint val;
    } exp_t;

    int         total = 0;
    int         bad = 0;
    longint     cyc = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] vco_pat[$];
    longint     m_acc = 0;
    longint     m_integ = 0;
    int         m_cnt = 0;
    longint     hold_exp = 0;
    longint     last_acc_edge = -1;
    bit         prev_closing = 0;
    bit         streaming = 0;
    bit         mon_en = 0;
    bit         cap_pending = 0;
    bit         rd_prev = 0;
    int         n_acc = 0;
    int         n_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint floor_shift(input longint x, input int k);
        longint d = 64'sd1 << k;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic longint sat(input longint x, input longint lo, input longint hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // One integrate-and-dump window closes: predict the new step and when it appears.
    function automatic void model_window(input longint at);
        exp_t e;
        m_integ = sat(m_integ + m_acc, -(64'sd1 << 31), (64'sd1 << 31) - 1);
        e.at  = at;
        e.val = sat(floor_shift(m_acc, KP_SH) + floor_shift(m_integ, KI_SH), -1024, 1023);
        exp_q.push_back(e);
        m_acc = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_clear();
        m_acc = 0;
        m_integ = 0;
        m_cnt = 0;
        hold_exp = 0;
        exp_q.delete();
        streaming = 0;
        last_acc_edge = -1;
    endfunction

    // VCO stand-in: answers each rd_en with the next pattern value, garbage otherwise.
    always @(negedge clk) begin
        if (rd_en) begin
            if (vco_pat.size() == 0) check("vco_pattern_underflow", 1, 0);
            else vco_out = vco_pat.pop_front();
            cap_pending = 1;
        end else begin
            if (!cap_pending) vco_out = 8'($urandom);
            cap_pending = 0;
        end
    end

    // Monitor, sampled 3 ns after each rising edge.
    always begin
        @(posedge clk);
        #3;
        if (!rst_n) begin
            rd_prev = 0;
        end else if (mon_en) begin
            if (rd_en) n_rd++;
            if (rd_en && rd_prev) check("rd_en_back_to_back", 1, 0);
            rd_prev = rd_en;
            if (step_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_step_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("step_edge", cyc, mon_e.at);
                    check("dlt_step", $signed(dlt_step), mon_e.val);
                    hold_exp = mon_e.val;
                end
            end else begin
                check("dlt_step_hold", $signed(dlt_step), hold_exp);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept edge (REQ cycle).
    task automatic send(input logic [7:0] rx, input logic [7:0] vco);
        int     n = 0;
        longint edge_no;
        rx_in = rx;
        rx_valid = 1'b1;
        vco_pat.push_back(vco);
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check("accept_timeout", 0, 1);
            rx_valid = 1'b0;
            return;
        end
        edge_no = cyc + 1;
        if (streaming && last_acc_edge >= 0)
            check("accept_interval", edge_no - last_acc_edge, prev_closing ? 4 : 3);
        last_acc_edge = edge_no;
        streaming = 1;
        n_acc++;
        m_acc += longint'($signed(rx)) * longint'($signed(vco));
        m_cnt++;
        prev_closing = (m_cnt == N_INT);
        if (prev_closing) model_window(edge_no + 3);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
        streaming = 0;
    endtask

    task automatic window(input logic [7:0] rx, input logic [7:0] vco, input int n);
        for (int i = 0; i < n; i++) send(rx, vco);
    endtask

    task automatic do_clr();
        rx_valid = 1'b0;
        clr = 1'b1;
        model_clear();
        @(negedge clk);
        clr = 1'b0;
        check("clr_dlt_step", $signed(dlt_step), 0);
        check("clr_step_valid", step_valid, 0);
        check("clr_rx_ready", rx_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset_rx_ready", rx_ready, 1);
        check("reset_dlt_step", $signed(dlt_step), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_rx_ready", rx_ready, 1);
            check("idle_rd_en", rd_en, 0);
            check("idle_step_valid", step_valid, 0);
        end

        // Single-sample handshake.
        send(8'd1, 8'd1);
        check("hs_rd_en_req", rd_en, 1);
        check("hs_ready_req", rx_ready, 0);
        @(negedge clk);
        check("hs_rd_en_cap", rd_en, 0);
        check("hs_ready_cap", rx_ready, 0);
        @(negedge clk);
        check("hs_ready_back", rx_ready, 1);
        check("hs_rd_en_idle", rd_en, 0);
        idle(2);
        do_clr();

        // PI arithmetic over two identical windows.
        window(8'd16, 8'd16, N_INT);
        idle(6);
        check("pi_window1", $signed(dlt_step), 68);
        window(8'd16, 8'd16, N_INT);
        idle(6);
        check("pi_window2", $signed(dlt_step), 72);

        // Asynchronous reset in the middle of a capture.
        send(8'd16, 8'd16);
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_clear();
        vco_pat.delete();
        #1;
        check("async_rx_ready", rx_ready, 1);
        check("async_rd_en", rd_en, 0);
        check("async_dlt_step", $signed(dlt_step), 0);
        check("async_step_valid", step_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Sign of the correction.
        window(8'd16, 8'hf0, N_INT);
        idle(6);
        check("sign_window", $signed(dlt_step), -68);

        // Saturation both ways.
        do_clr();
        window(8'd127, 8'd127, N_INT);
        idle(6);
        check("sat_pos", $signed(dlt_step), 1023);
        do_clr();
        window(8'h80, 8'd127, N_INT);
        idle(6);
        check("sat_neg", $signed(dlt_step), -1024);

        // Clear partway through a window.
        window(8'd16, 8'd16, 10);
        idle(2);
        do_clr();
        window(8'd16, 8'd16, N_INT);
        idle(6);
        check("clr_mid_window", $signed(dlt_step), 68);

        // Clear while a sample is in flight: it must not be counted.
        do_clr();
        rx_in = 8'd100;
        rx_valid = 1'b1;
        vco_pat.push_back(8'd100);
        n_acc++;
        @(negedge clk);
        do_clr();
        window(8'd16, 8'd16, N_INT);
        idle(6);
        check("clr_in_flight", $signed(dlt_step), 68);

        // Randomized windows with occasional source gaps.
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < N_INT; i++) begin
                if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 4));
                send(8'($urandom), 8'($urandom));
            end
        end
        idle(10);

        check("scoreboard_drained", exp_q.size(), 0);
        check("rd_en_per_accept", n_rd, n_acc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
